// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder with carry-in, one CHUNK-bit slice added per
// stage, behind an input capture register, under a valid/ready handshake with a
// global stall on backpressure.
// Optional feature: define ADDER_OVF_FLAG_EN to add the registered signed
// overflow output ovf_out.
module pipelined_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_out,
    output logic             c_out
`ifdef ADDER_OVF_FLAG_EN
    ,
    output logic             ovf_out
`endif
);

    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned CW     = CHUNK + 1;

    // Level 0 is the operand capture register; level j+1 holds the state after
    // chunk j has been added. Operands (skew) and partial sums (deskew) ride along.
    logic [STAGES:0]    vld;
    logic [STAGES:0]    cy;
    logic [WIDTH-1:0]   sum     [STAGES+1];
    logic [WIDTH-1:0]   opa     [STAGES];
    logic [WIDTH-1:0]   opb     [STAGES];
    logic [CHUNK:0]     part    [STAGES];
    logic [WIDTH-1:0]   nxt_sum [STAGES];
    logic               advance;

    // The whole pipe moves together unless a valid result is being held.
    assign advance  = !vld[STAGES] || out_ready;
    assign in_ready = advance && !rst;

    // Per-stage chunk add, merged into the partial sum travelling forward.
    always_comb begin
        for (int unsigned j = 0; j < STAGES; j++) begin
            part[j]    = CW'(opa[j][j*CHUNK +: CHUNK])
                       + CW'(opb[j][j*CHUNK +: CHUNK])
                       + CW'(cy[j]);
            nxt_sum[j] = sum[j];
            nxt_sum[j][j*CHUNK +: CHUNK] = part[j][CHUNK-1:0];
        end
    end

    // Pipeline registers: clear on reset, shift on advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            cy  <= '0;
            for (int unsigned k = 0; k <= STAGES; k++) begin
                sum[k] <= '0;
            end
            for (int unsigned k = 0; k < STAGES; k++) begin
                opa[k] <= '0;
                opb[k] <= '0;
            end
        end else if (advance) begin
            vld    <= {vld[STAGES-1:0], in_valid};
            opa[0] <= a_in;
            opb[0] <= b_in;
            cy[0]  <= c_in;
            sum[0] <= '0;
            for (int unsigned k = 1; k < STAGES; k++) begin
                opa[k] <= opa[k-1];
                opb[k] <= opb[k-1];
            end
            for (int unsigned j = 0; j < STAGES; j++) begin
                sum[j+1] <= nxt_sum[j];
                cy[j+1]  <= part[j][CHUNK];
            end
        end
    end

    assign out_valid = vld[STAGES];
    assign s_out     = sum[STAGES];
    assign c_out     = cy[STAGES];

`ifdef ADDER_OVF_FLAG_EN
    logic ovf_q;

    // Signed overflow: equal operand signs that differ from the sum sign,
    // registered alongside the top chunk so it stays aligned with s_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= (opa[STAGES-1][WIDTH-1] == opb[STAGES-1][WIDTH-1])
                  && (part[STAGES-1][CHUNK-1] != opa[STAGES-1][WIDTH-1]);
        end
    end

    assign ovf_out = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed testbench for pipelined_adder (WIDTH=16, CHUNK=4): reset, vector
// table with exact latency, streaming, backpressure and mid-flight reset.
// Overflow expectations are checked when ADDER_OVF_FLAG_EN is defined.
module tb_pipelined_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned STAGES = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             c_in = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] s_out;
    logic             c_out;
`ifdef ADDER_OVF_FLAG_EN
    logic             ovf_out;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [10];

    pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_out     (s_out),
        .c_out     (c_out)
`ifdef ADDER_OVF_FLAG_EN
        ,
        .ovf_out   (ovf_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive n operand sets, optionally stalling the consumer, and score results
    // against a full-width reference sum in acceptance order.
    task automatic run_stream(input int n, input int stall_at, input int stall_len, input string tag);
        logic [16:0] q [$];
        logic [16:0] exp_sum;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] held_s;
        logic        held_c;
        logic        have_held;
        int sent, got, cyc, first, last;
        sent = 0; got = 0; cyc = 0; first = -1; last = -1; have_held = 1'b0;
        held_s = '0; held_c = 1'b0;
        while (got < n && cyc < 200) begin
            a  = 16'(sent * 32'h2345 + 32'h0F00);
            b  = 16'(32'hFFFF - sent * 32'h0123);
            ci = sent[0];
            in_valid  = (sent < n);
            a_in      = a;
            b_in      = b;
            c_in      = ci;
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (!out_ready && out_valid) begin
                check({tag, " stall_in_ready"}, 32'(in_ready), 32'd0);
                if (!have_held) begin
                    held_s    = s_out;
                    held_c    = c_out;
                    have_held = 1'b1;
                end else begin
                    check({tag, " stall_hold_s"}, 32'(s_out), 32'(held_s));
                    check({tag, " stall_hold_c"}, 32'(c_out), 32'(held_c));
                end
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check({tag, " unexpected_result"}, 32'd1, 32'd0);
                end else begin
                    exp_sum = q.pop_front();
                    check({tag, " sum"},   32'(s_out), 32'(exp_sum[15:0]));
                    check({tag, " carry"}, 32'(c_out), 32'(exp_sum[16]));
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (in_valid && in_ready) begin
                q.push_back(17'(a) + 17'(b) + 17'(ci));
                sent++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, " result_count"}, 32'(got), 32'(n));
        check({tag, " result_span"},  32'(last - first), 32'(n - 1 + stall_len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h1234, 16'h0FED, 1'b1, 16'h2222, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[9] = '{16'h5555, 16'h2AAA, 1'b1, 16'h8000, 1'b0, 1'b1};

        // Reset held for 3 cycles with in_valid asserted.
        rst = 1'b1; in_valid = 1'b1; a_in = 16'h0005; b_in = 16'h0006;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_s_out",     32'(s_out),     32'd0);
            check("rst_c_out",     32'(c_out),     32'd0);
            check("rst_in_ready",  32'(in_ready),  32'd0);
`ifdef ADDER_OVF_FLAG_EN
            check("rst_ovf_out",   32'(ovf_out),   32'd0);
`endif
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_release_in_ready", 32'(in_ready), 32'd1);

        // Vector table, one operation at a time, exact latency.
        for (int i = 0; i < 10; i++) begin
            a_in = vecs[i].a; b_in = vecs[i].b; c_in = vecs[i].ci;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            check("tbl_in_ready", 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            for (int k = 1; k < int'(STAGES); k++) begin
                step();
                check("tbl_early_valid", 32'(out_valid), 32'd0);
            end
            step();
            check("tbl_out_valid", 32'(out_valid), 32'd1);
            check("tbl_s_out",     32'(s_out),     32'(vecs[i].s));
            check("tbl_c_out",     32'(c_out),     32'(vecs[i].co));
`ifdef ADDER_OVF_FLAG_EN
            check("tbl_ovf_out",   32'(ovf_out),   32'(vecs[i].ov));
`endif
        end

        // Back-to-back streaming, then a 5-cycle consumer stall mid-stream.
        step();
        run_stream(8, 1000, 0, "stream");
        step();
        run_stream(10, 6, 5, "backpressure");

        // Mid-flight reset drops three in-flight operations.
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in = 16'(32'h1000 * (i + 1)); b_in = 16'h0101; c_in = 1'b1;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("midrst_flush_valid", 32'(out_valid), 32'd0);
        end
        a_in = 16'h0001; b_in = 16'h0002; c_in = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k < int'(STAGES); k++) begin
            step();
            check("midrst_early_valid", 32'(out_valid), 32'd0);
        end
        step();
        check("midrst_out_valid", 32'(out_valid), 32'd1);
        check("midrst_s_out",     32'(s_out),     32'h0003);
        check("midrst_c_out",     32'(c_out),     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
